// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg: shared types and constants for the SRAM RMW controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rmw_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl_if: core request/response channel (master = core). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_rmw_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BE_WIDTH-1:0]   req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_byte_merge.sv
// ---------------------------------------------------------------------------
// sram_byte_merge: per-byte select of new over old word under byte enables. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_byte_merge
  import sram_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_byte
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl: load/store front end for a maskless single-port SRAM, doing
// read-modify-write for partial stores. Optional: SRAM_RMW_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_rmw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  sram_rmw_ctrl_if.slave        bus,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
`ifdef SRAM_RMW_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_rd,
  output logic [STAT_WIDTH-1:0] stat_wr,
  output logic [STAT_WIDTH-1:0] stat_rmw
`endif
);

  localparam int BE_WIDTH = be_width(DATA_WIDTH);

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_WIDTH-1:0]   r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_din;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_merged;

  sram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word (dout0),
    .new_word (r_wdata),
    .be       (r_be),
    .merged   (w_merged)
  );

  // SRAM strobes decode from r_state only, so req_* never reaches the macro combinationally.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    csb0          = 1'b1;
    web0          = 1'b1;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!bus.req_we)           w_next = RD;
          else if (&bus.req_be)      w_next = WR;
          else if (bus.req_be == '0) w_next = RESP;
          else                       w_next = RD;
        end
      end
      RD: begin
        csb0   = 1'b0;
        w_next = RDW;
      end
      RDW:  w_next = r_we ? WR : RESP;
      WR: begin
        csb0   = 1'b0;
        web0   = 1'b0;
        w_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_din   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_be    <= bus.req_be;
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            if (bus.req_we) r_din <= bus.req_wdata;
          end
        end
        // dout0 settled at the preceding negedge; merge or return it now.
        RDW: begin
          if (r_we) r_din   <= w_merged;
          else      r_rdata <= dout0;
        end
        WR:      r_rdata <= '0;
        default: ;
      endcase
    end
  end

  assign addr0         = r_addr;
  assign din0          = r_din;
  assign bus.rsp_rdata = r_rdata;

`ifdef SRAM_RMW_STATS_EN
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_rmw <= '0;
    end else if (r_state == RESP && bus.rsp_ready) begin
      if (!r_we) begin
        if (stat_rd != '1) stat_rd <= stat_rd + 1'b1;
      end else if (&r_be) begin
        if (stat_wr != '1) stat_wr <= stat_wr + 1'b1;
      end else if (r_be != '0) begin
        if (stat_rmw != '1) stat_rmw <= stat_rmw + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_rmw_ctrl: directed bench with a behavioural 32x32 SRAM macro model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_rmw_ctrl;
  import sram_ctrl_pkg::*;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        csb0, web0;
  logic [4:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
`ifdef SRAM_RMW_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_rmw;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int n_hs     = 0;
  int n_rd     = 0;
  int n_wr     = 0;

  sram_rmw_ctrl_if bus ();

  sram_rmw_ctrl dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
`ifdef SRAM_RMW_STATS_EN
    ,
    .stat_rd  (stat_rd),
    .stat_wr  (stat_wr),
    .stat_rmw (stat_rmw)
`endif
  );

  always #5 clk0 = ~clk0;

  // Macro model: controls captured at posedge, read/write resolved at the negedge.
  logic [31:0] mem [32];
  logic        cap_csb = 1'b1;
  logic        cap_web = 1'b1;
  logic [4:0]  cap_addr;
  logic [31:0] cap_din;

  always @(posedge clk0) begin
    cap_csb  <= csb0;
    cap_web  <= web0;
    cap_addr <= addr0;
    cap_din  <= din0;
    if (!csb0) begin
      if (!web0) n_wr++;
      else       n_rd++;
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) n_hs++;
  end

  always @(negedge clk0) begin
    if (!cap_csb) begin
      if (!cap_web) mem[cap_addr] <= cap_din;
      else          dout0 <= mem[cap_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, " csb0"},      32'(csb0), 32'd1);
    chk({tag, " web0"},      32'(web0), 32'd1);
    chk({tag, " addr0"},     32'(addr0), 32'd0);
    chk({tag, " din0"},      din0, 32'd0);
  endtask

  // Starts #1 after a posedge with the controller idle; ends the same way.
  task automatic do_req(input string tag, input logic we, input logic [4:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input int stall);
    int lat;
    int hs0;
    lat = 0;
    hs0 = n_hs;
    if (stall > 0) bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
    @(posedge clk0); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk0);
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    for (int s = 1; s < stall; s++) begin
      @(negedge clk0);
      chk({tag, " stall rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " stall rdata"},     bus.rsp_rdata, exp_rdata);
      chk({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, " stall csb0"},      32'(csb0), 32'd1);
    end
    if (stall > 0) begin
      @(posedge clk0); #1;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk0); #1;
    chk({tag, " handshakes"}, 32'(n_hs - hs0), 32'd1);
    chk({tag, " rsp_valid after"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int r0;
    int w0;
    int hs0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | 32'(i);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk0);
    @(negedge clk0);
    chk_reset_outputs("reset");
    @(posedge clk0); #1;
    rst_n = 1'b1;

    r0 = n_rd; w0 = n_wr;
    do_req("full_st", 1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF, 2, 32'h0, 0);
    chk("full_st sram writes", 32'(n_wr - w0), 32'd1);
    chk("full_st sram reads",  32'(n_rd - r0), 32'd0);
    do_req("ld3_a", 1'b0, 5'd3, 4'h0, 32'h0, 3, 32'hDEAD_BEEF, 0);

    r0 = n_rd; w0 = n_wr;
    do_req("part_st", 1'b1, 5'd3, 4'h2, 32'h0000_AA00, 4, 32'h0, 0);
    chk("part_st sram reads",  32'(n_rd - r0), 32'd1);
    chk("part_st sram writes", 32'(n_wr - w0), 32'd1);
    do_req("ld3_b", 1'b0, 5'd3, 4'h0, 32'h0, 3, 32'hDEAD_AAEF, 0);

    r0 = n_rd; w0 = n_wr;
    do_req("be0_st", 1'b1, 5'd7, 4'h0, 32'hFFFF_FFFF, 1, 32'h0, 0);
    chk("be0_st sram accesses", 32'((n_rd - r0) + (n_wr - w0)), 32'd0);
    do_req("ld7", 1'b0, 5'd7, 4'h0, 32'h0, 3, 32'hA500_0007, 0);

    do_req("ld3_stall", 1'b0, 5'd3, 4'h0, 32'h0, 3, 32'hDEAD_AAEF, 5);

    // Reset while a load sits in RDW.
    hs0 = n_hs;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd3;
    @(posedge clk0); #1;
    bus.req_valid = 1'b0;
    @(posedge clk0); #1;
    rst_n = 1'b0;
    @(posedge clk0);
    @(negedge clk0);
    chk_reset_outputs("mid_rst");
    @(posedge clk0); #1;
    rst_n = 1'b1;
    @(negedge clk0);
    chk("mid_rst release req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst no response", 32'(n_hs - hs0), 32'd0);
    @(posedge clk0); #1;
    do_req("ld3_after_rst", 1'b0, 5'd3, 4'h0, 32'h0, 3, 32'hDEAD_AAEF, 0);

    rst_n = 1'b0;
    @(posedge clk0); #1;
    rst_n = 1'b1;
    do_req("st31", 1'b1, 5'd31, 4'hF, 32'h1111_1111, 2, 32'h0, 0);
    do_req("st0",  1'b1, 5'd0,  4'hF, 32'h2222_2222, 2, 32'h0, 0);
    do_req("ld31", 1'b0, 5'd31, 4'h0, 32'h0, 3, 32'h1111_1111, 0);
    do_req("ld0",  1'b0, 5'd0,  4'h0, 32'h0, 3, 32'h2222_2222, 0);
`ifdef SRAM_RMW_STATS_EN
    chk("stat_wr",  32'(stat_wr),  32'd2);
    chk("stat_rd",  32'(stat_rd),  32'd2);
    chk("stat_rmw", 32'(stat_rmw), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_rmw_ctrl.md
Name: sram_rmw_ctrl

Overview:
- Request-side controller placed directly upstream of the 32x32 single-port SRAM macro (csb0/web0/addr0/din0/dout0 interface).
- Converts core load/store requests (valid/ready, byte enables) into SRAM accesses.
- Performs read-modify-write for partial writes, because the macro has no write mask.
- Returns read data and write acks on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 5, word address width; matches the macro.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden).

Ports:
- clk0  in  1  clock; same clock as the SRAM macro.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller accepts request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_WIDTH  word address.
- req_be  in  BE_WIDTH  byte enables (stores only; ignored on loads).
- req_wdata  in  DATA_WIDTH  store data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for store acks.
- csb0  out  1  SRAM chip select, active-low.
- web0  out  1  SRAM write enable, active-low.
- addr0  out  ADDR_WIDTH  SRAM address.
- din0  out  DATA_WIDTH  SRAM write data.
- dout0  in  DATA_WIDTH  SRAM read data; valid after the negedge following the capturing posedge.

Behaviour:
- Reset values (synchronous on rst_n=0 at posedge clk0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - csb0=1, web0=1, addr0=0, din0=0.
  - Request latches cleared.
- FSM states: IDLE, RD, RDW, WR, RESP.
- SRAM control: csb0=0 only in RD and WR; web0=0 only in WR.
  - addr0 and din0 come from latches and are stable through RD/RDW/WR.
  - All SRAM outputs decode from registered state only (no combinational path from req_*).
- IDLE:
  - req_ready=1. On req_valid at the edge: latch we/addr/be/wdata.
  - Load -> RD.
  - Store with be=all ones -> WR (din0=wdata).
  - Store with be=0 -> RESP directly; no SRAM access.
  - Other store -> RD.
- RD: SRAM read issued; the macro captures at the posedge ending RD. -> RDW.
- RDW:
  - csb0=1; dout0 is valid after the mid-cycle negedge.
  - At the posedge ending RDW, capture dout0.
  - Load -> RESP with rsp_rdata=dout0.
  - Partial store -> WR with din0 = per byte i: be[i] ? wdata byte i : dout0 byte i.
- WR: SRAM write issued; committed at the following negedge inside the macro. -> RESP with rsp_rdata=0.
- RESP: rsp_valid=1, req_ready=0; rsp_rdata held stable. On rsp_ready -> IDLE.
- req_ready=1 only in IDLE. No new request is accepted in the same cycle that RESP completes.
- Latency, counted in cycles from the accept edge to the first rsp_valid cycle:
  - load = 3; full store = 2; partial store = 4; be=0 store = 1.
- Address: all 2^ADDR_WIDTH words are legal; 31 and 0 need no special handling.
- Reset mid-operation:
  - A WR in progress at the reset edge still commits (the macro captured it on that edge).
  - RD/RDW/RESP are aborted with no response.
  - req_ready=1 on the first cycle after rst_n rises.

Optional Feature:
- Macro SRAM_RMW_STATS_EN.
- Defined:
  - Adds outputs stat_rd, stat_wr, stat_rmw, each 16 bits.
  - They count completed loads, full stores and partial stores, at RESP exit.
  - Saturating at 0xFFFF; reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_ctrl_pkg holds:
  - FSM state enum (IDLE, RD, RDW, WR, RESP).
  - Default DATA_WIDTH/ADDR_WIDTH constants; BE_WIDTH derivation.
  - Stats counter width constant.
- One sub-module: sram_byte_merge, purely combinational.
  - Inputs: old word, new word, be. Output: merged word.
  - Instantiated for the RDW->WR din0 path.

Test Plan:
- Full store addr=3, data=0xDEADBEEF, be=0xF -> rsp_valid 2 cycles after accept. Then load addr=3 -> rsp_rdata=0xDEADBEEF 3 cycles after accept.
- Partial store addr=3, data=0x0000AA00, be=0x2 -> one RD then one WR seen on csb0/web0; rsp after 4 cycles. Then load addr=3 -> 0xDEADAAEF.
- Store be=0 to addr=7 -> rsp_valid next cycle with rsp_rdata=0; csb0 stays 1 throughout. Then load addr=7 returns its prior content unchanged.
- Load, with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, csb0=1. Single completion when rsp_ready=1.
- rst_n=0 during RDW of a load -> no rsp_valid; all outputs at reset values; req_ready=1 the cycle after release. Then a load returns correct data.
- Back-to-back full stores addr=31 (0x11111111) then addr=0 (0x22222222), then loads of both -> exact values, no aliasing. With SRAM_RMW_STATS_EN: stat_wr=2, stat_rd=2, stat_rmw=0.
